// File: rtl/eeg_sample_loader_pkg.sv
// Shared defines for the EEG load path: ADC and int-res types, loader states.
// Imported by the loader top and the ADC-to-fixed-point converter.
package eeg_sample_loader_pkg;

  localparam int ADC_BITWIDTH = 16;
  localparam int Q_STO_INT_RES_DOUBLE = 20;
  localparam int INT_RES_DW_BITS = 30;
  localparam int INT_RES_ADDR_W = 16;

  localparam int NUM_PATCHES = 60;
  localparam int PATCH_LEN = 64;
  localparam int EEG_NUM_SAMPLES = NUM_PATCHES * PATCH_LEN;
  localparam int EEG_INPUT_MEM_BASE = 0;

  localparam int ADC_TO_DW_SHIFT =
    Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH;

  typedef logic [ADC_BITWIDTH-1:0] AdcData_t;
  typedef logic [INT_RES_DW_BITS-1:0] IntResDouble_t;
  typedef logic [INT_RES_ADDR_W-1:0] IntResAddr_t;

  typedef enum logic {
    SINGLE_WIDTH,
    DOUBLE_WIDTH
  } DataWidth_t;

  typedef enum logic {
    INT_RES_SW_FX,
    INT_RES_DW_FX
  } FxFormatIntRes_t;

  typedef enum logic [1:0] {
    IDLE_LOAD,
    LOADING,
    LOAD_DONE
  } LoaderState_t;

endpackage

// File: rtl/eeg_sample_loader_adc_to_fx_converter.sv
// Unsigned 16b ADC sample to double-width int-res fixed point.
// Real value is adc/2^16, so the sample lands just below the binary point.
module adc_to_fx_converter
  import eeg_sample_loader_pkg::*;
(
  input  AdcData_t      adc,
  output IntResDouble_t fx
);

  localparam int PAD_W =
    INT_RES_DW_BITS - ADC_BITWIDTH - ADC_TO_DW_SHIFT;

  assign fx = {{PAD_W{1'b0}}, adc,
               {ADC_TO_DW_SHIFT{1'b0}}};

endmodule

// File: rtl/eeg_sample_loader.sv
// Streams one window of ADC samples into EEG_INPUT_MEM of int-res memory.
// One-entry holding register between the ADC handshake and the write port.
module eeg_sample_loader
  import eeg_sample_loader_pkg::*;
#(
  parameter int NUM_SAMPLES = EEG_NUM_SAMPLES,
  parameter int BASE_ADDR = EEG_INPUT_MEM_BASE,
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            adc_valid,
  input  AdcData_t        adc_data,
  output logic            adc_ready,
  output logic            wr_en,
  output IntResAddr_t     wr_addr,
  output IntResDouble_t   wr_data,
  output DataWidth_t      wr_width,
  output FxFormatIntRes_t wr_format,
  input  logic            wr_ack,
  output logic            busy,
  output logic            done,
  output logic [CNT_W-1:0] sample_cnt
);

  LoaderState_t  state;
  logic          hold_valid;
  IntResDouble_t hold_data;
  IntResDouble_t conv_data;
  logic [CNT_W-1:0] acc_cnt;
  logic          xfer;
  logic          ack;

  adc_to_fx_converter u_conv (
    .adc (adc_data),
    .fx  (conv_data)
  );

  // Accept guard keeps samples past the window in the ADC stream.
  assign adc_ready = (state == LOADING)
                  && (acc_cnt < CNT_W'(NUM_SAMPLES))
                  && (!hold_valid || wr_ack);

  assign xfer = adc_valid && adc_ready;
  assign ack  = wr_ack && hold_valid;

  assign wr_en     = hold_valid;
  assign wr_data   = hold_data;
  assign wr_addr   = IntResAddr_t'(BASE_ADDR)
                   + IntResAddr_t'(sample_cnt);
  assign wr_width  = DOUBLE_WIDTH;
  assign wr_format = INT_RES_DW_FX;
  assign busy      = (state == LOADING);
  assign done      = (state == LOAD_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LOAD;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      acc_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      unique case (state)
        IDLE_LOAD: begin
          if (start) begin
            state      <= LOADING;
            hold_valid <= 1'b0;
            acc_cnt    <= '0;
            sample_cnt <= '0;
          end
        end
        LOADING: begin
          if (xfer) begin
            hold_data  <= conv_data;
            hold_valid <= 1'b1;
            acc_cnt    <= acc_cnt + CNT_W'(1);
          end else if (ack) begin
            hold_valid <= 1'b0;
          end
          if (ack) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (sample_cnt == CNT_W'(NUM_SAMPLES - 1))
              state <= LOAD_DONE;
          end
        end
        LOAD_DONE: state <= IDLE_LOAD;
        default:   state <= IDLE_LOAD;
      endcase
    end
  end

endmodule
